mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, between the EX/MEM register and the write-back mux.
- Drives a handshaked data-memory port (req/gnt, then rvalid) and formats store byte lanes.
- Sign/zero-extends load data.
- Contains the MEM/WB pipeline register whose outputs feed write-back directly.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  EX/MEM slot holds a real instruction
- ex_alu_result  in  ADDR_W  ALU result / effective address
- ex_store_data  in  32  rs2 value for stores
- ex_funct3  in  3  access size/sign (RV32I encoding)
- ex_MemRead  in  1  load
- ex_MemWrite  in  1  store
- ex_MemtoReg  in  1  passed to WB
- ex_RegWrite  in  1  passed to WB
- ex_rd  in  REG_ADDR_W  destination register
- mem_stall  out  1  EX/MEM contents must be held; upstream freezes
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  raw load word
- wb_valid  out  1  MEM/WB valid
- wb_alu_result  out  32  registered ALU result
- wb_mem_read_data  out  32  registered extended load data
- wb_MemtoReg  out  1  registered
- wb_RegWrite  out  1  registered; forced 0 when wb_valid=0
- wb_rd  out  REG_ADDR_W  registered

Behaviour:
- Reset: when rst_n=0 at a clk edge, state becomes IDLE and all wb_* outputs become 0. dmem_req is forced 0 while rst_n=0. A reset mid-transaction abandons it; a later rvalid is ignored in IDLE.
- mem_op = ex_valid & (ex_MemRead | ex_MemWrite). Upstream holds all ex_* inputs stable while mem_stall=1.
- dmem_req = (IDLE & mem_op) | WAIT_GNT. Address, be, wdata and we are driven combinationally from ex_* inputs.
- FSM transitions:
  - IDLE: non-mem or ex_valid=0 → retire, stall 0.
  - IDLE: mem_op & !gnt → WAIT_GNT, stall 1.
  - IDLE: load & gnt → WAIT_RVALID, stall 1.
  - IDLE: store & gnt → retire, stall 0.
  - WAIT_GNT: !gnt → stay, stall 1.
  - WAIT_GNT: store & gnt → IDLE, retire, stall 0.
  - WAIT_GNT: load & gnt → WAIT_RVALID, stall 1.
  - WAIT_RVALID: !rvalid → stay, stall 1.
  - WAIT_RVALID: rvalid → IDLE, retire, stall 0.
- rvalid is only honoured in WAIT_RVALID (earliest one cycle after gnt).
- Retire: at the clk edge, the MEM/WB register captures valid, ALU result, extended load data, MemtoReg, RegWrite and rd. Latency is 1 cycle for non-memory instructions and stores with same-cycle gnt; a load takes at least 2 cycles.
- Stall cycle: MEM/WB captures a bubble (wb_valid=0, wb_RegWrite=0; other fields don't-care, keep prior value).
- Store lanes (off = addr[1:0]):
  - SB: be = 0001<<off, wdata = {4{byte}}.
  - SH: be = 0011<<{off[1],0}, wdata = {2{half}}.
  - SW: be = 1111.
- Loads select a byte/half by offset:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Unused funct3 is treated as LW.
- Non-load retire: wb_mem_read_data is 0.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- When defined:
  - Misaligned means halfword with off[0]=1, or word with off≠0.
  - A misaligned access issues no dmem_req and retires in 1 cycle with wb_RegWrite=0.
  - Extra outputs misalign_exc (1-cycle pulse, registered alongside wb_*, reset 0) and misalign_addr (ADDR_W, registered full byte address, reset 0).
- When undefined: no extra ports; low address bits are ignored for halfword (off[0]) and word (off[1:0]) alignment.

Decomposition:
- Package mem_pkg holds:
  - funct3 localparams F3_B/H/W/BU/HU
  - mem_state_t enum (IDLE, WAIT_GNT, WAIT_RVALID)
- Sub-module lsu_align (combinational) produces be/wdata from funct3, offset and store data, and the extended load word from funct3, offset and rdata.
- mem_stage holds the FSM and the MEM/WB register.

Test Plan:
- ADD with ex_alu_result=0x1234, RegWrite=1, rd=5 → next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=5; mem_stall never 1.
- SB at addr 0x103, data 0xAB, gnt same cycle → dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, mem_stall=0.
- LB at addr 0x101, gnt cycle 0, rvalid cycle 2 with rdata=0x0000_80FF → mem_stall=1 cycles 0–1; then wb_mem_read_data=0xFFFF_FF80, wb_MemtoReg=1.
- LHU at addr 0x202, gnt delayed 3 cycles, then rvalid with 0xBEEF_0000 → dmem_req held 4 cycles; bubble wb_valid=0 during stall; then result 0x0000_BEEF.
- rst_n=0 during WAIT_RVALID, then rvalid pulse after release → state IDLE, all wb_* = 0, stray rvalid produces no retire.
- MISALIGN_TRAP_EN: LW at 0x302 → no dmem_req, misalign_exc=1 for one cycle, misalign_addr=0x302, wb_RegWrite=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I memory-access stage: funct3 access codes,
// the MEM FSM state type and the misalignment predicate.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_GNT    = 2'd1,
      WAIT_RVALID = 2'd2
   } mem_state_t;

   // funct3[1:0] encodes access size; the unused size code behaves as a word.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      unique case (funct3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores and byte/half selection plus sign/zero
// extension for loads. Purely combinational.
module lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_ext_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = store_data_i;
      unique case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            be_o    = 4'b0011 << {off_i[1], 1'b0};
            wdata_o = {2{store_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = rdata_i[7:0];
      unique case (off_i)
         2'd0: ld_byte = rdata_i[7:0];
         2'd1: ld_byte = rdata_i[15:8];
         2'd2: ld_byte = rdata_i[23:16];
         2'd3: ld_byte = rdata_i[31:24];
      endcase
      ld_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      unique case (funct3_i)
         F3_B:    load_ext_o = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   load_ext_o = {24'h0, ld_byte};
         F3_H:    load_ext_o = {{16{ld_half[15]}}, ld_half};
         F3_HU:   load_ext_o = {16'h0, ld_half};
         default: load_ext_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RV32I pipeline: data-memory handshake FSM, stall
// generation and the MEM/WB register. Optional trap on misaligned access: MISALIGN_TRAP_EN.
module mem_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic [ADDR_W-1:0]     ex_alu_result,
   input  logic [31:0]           ex_store_data,
   input  logic [2:0]            ex_funct3,
   input  logic                  ex_MemRead,
   input  logic                  ex_MemWrite,
   input  logic                  ex_MemtoReg,
   input  logic                  ex_RegWrite,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_stall,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_W-1:0]     dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [31:0]           dmem_wdata,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rvalid,
   input  logic [31:0]           dmem_rdata,
   output logic                  wb_valid,
   output logic [31:0]           wb_alu_result,
   output logic [31:0]           wb_mem_read_data,
   output logic                  wb_MemtoReg,
   output logic                  wb_RegWrite,
   output logic [REG_ADDR_W-1:0] wb_rd
`ifdef MISALIGN_TRAP_EN
  ,output logic                  misalign_exc,
   output logic [ADDR_W-1:0]     misalign_addr
`endif
);

   mem_state_t            state_q, state_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [31:0]           wb_alu_q, wb_alu_d;
   logic [31:0]           wb_rdata_q, wb_rdata_d;
   logic                  wb_m2r_q, wb_m2r_d;
   logic                  wb_rw_q, wb_rw_d;
   logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;

   logic [1:0]  off;
   logic        misaligned;
   logic        mem_go;
   logic        is_load;
   logic        retire;
   logic        req_raw;
   logic [31:0] load_ext;

   assign off     = ex_alu_result[1:0];
   assign is_load = ex_MemRead;

`ifdef MISALIGN_TRAP_EN
   assign misaligned = ex_valid & (ex_MemRead | ex_MemWrite) & is_misaligned(ex_funct3, off);
`else
   assign misaligned = 1'b0;
`endif

   // A misaligned access never touches memory; it retires like an ALU op.
   assign mem_go = ex_valid & (ex_MemRead | ex_MemWrite) & ~misaligned;

   lsu_align u_lsu_align (
      .funct3_i     (ex_funct3),
      .off_i        (off),
      .store_data_i (ex_store_data),
      .rdata_i      (dmem_rdata),
      .be_o         (dmem_be),
      .wdata_o      (dmem_wdata),
      .load_ext_o   (load_ext)
   );

   assign dmem_we   = ex_MemWrite;
   assign dmem_addr = {ex_alu_result[ADDR_W-1:2], 2'b00};
   assign dmem_req  = req_raw & rst_n;

   always_comb begin
      state_d   = state_q;
      mem_stall = 1'b0;
      retire    = 1'b0;
      req_raw   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!mem_go) begin
               retire = 1'b1;
            end else begin
               req_raw = 1'b1;
               if (!dmem_gnt) begin
                  state_d   = WAIT_GNT;
                  mem_stall = 1'b1;
               end else if (is_load) begin
                  state_d   = WAIT_RVALID;
                  mem_stall = 1'b1;
               end else begin
                  retire = 1'b1;
               end
            end
         end
         WAIT_GNT: begin
            req_raw = 1'b1;
            if (!dmem_gnt) begin
               mem_stall = 1'b1;
            end else if (is_load) begin
               state_d   = WAIT_RVALID;
               mem_stall = 1'b1;
            end else begin
               state_d = IDLE;
               retire  = 1'b1;
            end
         end
         WAIT_RVALID: begin
            if (dmem_rvalid) begin
               state_d = IDLE;
               retire  = 1'b1;
            end else begin
               mem_stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stall cycles insert a bubble; payload fields simply hold.
   always_comb begin
      wb_valid_d = 1'b0;
      wb_rw_d    = 1'b0;
      wb_alu_d   = wb_alu_q;
      wb_rdata_d = wb_rdata_q;
      wb_m2r_d   = wb_m2r_q;
      wb_rd_d    = wb_rd_q;
      if (retire) begin
         wb_valid_d = ex_valid;
         wb_rw_d    = ex_valid & ex_RegWrite & ~misaligned;
         wb_alu_d   = 32'(ex_alu_result);
         wb_rdata_d = (ex_valid & ex_MemRead & ~misaligned) ? load_ext : 32'h0;
         wb_m2r_d   = ex_MemtoReg;
         wb_rd_d    = ex_rd;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wb_valid_q <= 1'b0;
         wb_alu_q   <= '0;
         wb_rdata_q <= '0;
         wb_m2r_q   <= 1'b0;
         wb_rw_q    <= 1'b0;
         wb_rd_q    <= '0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= wb_valid_d;
         wb_alu_q   <= wb_alu_d;
         wb_rdata_q <= wb_rdata_d;
         wb_m2r_q   <= wb_m2r_d;
         wb_rw_q    <= wb_rw_d;
         wb_rd_q    <= wb_rd_d;
      end
   end

   assign wb_valid         = wb_valid_q;
   assign wb_alu_result    = wb_alu_q;
   assign wb_mem_read_data = wb_rdata_q;
   assign wb_MemtoReg      = wb_m2r_q;
   assign wb_RegWrite      = wb_rw_q;
   assign wb_rd            = wb_rd_q;

`ifdef MISALIGN_TRAP_EN
   logic              exc_q;
   logic [ADDR_W-1:0] exc_addr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exc_q      <= 1'b0;
         exc_addr_q <= '0;
      end else begin
         exc_q <= retire & misaligned;
         if (retire && misaligned) exc_addr_q <= ex_alu_result;
      end
   end

   assign misalign_exc  = exc_q;
   assign misalign_addr = exc_addr_q;
`endif

endmodule
